// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter: FSM state encoding,
// divider op type and the result forced onto a timed-out operation.
package div_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef logic [1:0] op_t;

    localparam int unsigned MAX_XLEN = 64;

    // Sliced down to XLEN at the point of use.
    localparam logic [MAX_XLEN-1:0] TIMEOUT_RES = '1;

endpackage

// File: rtl/div_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or above ptr, wrapping modulo
// NREQ. Purely combinational.
module rr_picker #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   grant,
    output logic            any
);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        grant = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!any && req[PW'(idx)]) begin
                grant = PW'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between NREQ requesters with round-robin
// arbitration, per-owner flush and a watchdog that forces completion.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    input  logic [NREQ*2-1:0]    req_op,
    input  logic [NREQ-1:0]      flush,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [XLEN-1:0]      resp_res,
    output logic                 div_v,
    output logic [XLEN-1:0]      div_a,
    output logic [XLEN-1:0]      div_b,
    output op_t                  div_op,
    input  logic [XLEN-1:0]      div_res,
    input  logic                 div_res_valid,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT) + 1;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   grant;
    logic            any_req;
    logic            killed;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    op_t             op_q;
    logic [XLEN-1:0] res_q;
    logic [WW-1:0]   wdog;
    logic            err_q;

    logic [NREQ-1:0] req_elig;
    logic            accept;
    logic            own_flush;
    logic            wd_hit;
    logic            done;
    logic            wd_expire;

    assign req_elig  = req_valid & ~flush;
    assign own_flush = flush[owner];
    // No handshake while reset is held: the op registers could not capture it.
    assign accept    = (state == S_IDLE) && any_req && rst_n;
    assign wd_hit    = (wdog == WW'(TIMEOUT - 1));
    assign done      = (state == S_WAIT) && (div_res_valid || wd_hit);
    assign wd_expire = (state == S_WAIT) && !div_res_valid && wd_hit;

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req   (req_elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                // A flush arriving with the completion still kills the op.
                if (done) begin
                    state_nx = (killed || own_flush) ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                if (own_flush || resp_ready[owner]) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_res   = '0;
        div_v      = 1'b0;
        busy       = (state != S_IDLE);
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
        if (state == S_START) begin
            div_v = 1'b1;
        end
        if (state == S_RESP) begin
            resp_valid[owner] = 1'b1;
            resp_res          = res_q;
        end
    end

    assign div_a       = a_q;
    assign div_b       = b_q;
    assign div_op      = op_q;
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            owner  <= '0;
            killed <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            res_q  <= '0;
            wdog   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= req_a[grant*XLEN +: XLEN];
                b_q    <= req_b[grant*XLEN +: XLEN];
                op_q   <= req_op[grant*2 +: 2];
                owner  <= grant;
                killed <= 1'b0;
                rr_ptr <= (grant == PW'(NREQ - 1)) ? '0 : grant + PW'(1);
            end
            if ((state == S_START || state == S_WAIT) && own_flush) begin
                killed <= 1'b1;
            end
            if (state == S_START) begin
                wdog <= '0;
            end else if (state == S_WAIT) begin
                wdog <= wdog + WW'(1);
            end
            if ((state == S_WAIT) && div_res_valid) begin
                res_q <= div_res;
            end else if (wd_expire) begin
                res_q <= TIMEOUT_RES[XLEN-1:0];
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider of configurable
// latency (or one that never answers).
module tb_div_arbiter;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [XLEN-1:0]      a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [NREQ*2-1:0]    req_op = '0;
    logic [NREQ-1:0]      flush = '0;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready = '0;
    logic [XLEN-1:0]      resp_res;
    logic                 div_v;
    logic [XLEN-1:0]      div_a, div_b;
    logic [1:0]           div_op;
    logic [XLEN-1:0]      div_res;
    logic                 div_res_valid;
    logic                 busy;
    logic                 err_timeout;

    int errors = 0;
    int checks = 0;

    div_arbiter #(
        .NREQ    (NREQ),
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         ({a1, a0}),
        .req_b         ({b1, b0}),
        .req_op        (req_op),
        .flush         (flush),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_res      (resp_res),
        .div_v         (div_v),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_op        (div_op),
        .div_res       (div_res),
        .div_res_valid (div_res_valid),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    // Divider model: result pulse dly cycles after the start pulse.
    int unsigned dly = 1;
    bit          never = 1'b0;
    logic [XLEN-1:0] m_a, m_b;
    int unsigned cnt;
    bit          active;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active        <= 1'b0;
            cnt           <= 0;
            div_res_valid <= 1'b0;
            div_res       <= '0;
            m_a           <= '0;
            m_b           <= '0;
        end else begin
            div_res_valid <= 1'b0;
            if (div_v && !never) begin
                m_a <= div_a;
                m_b <= div_b;
                if (dly <= 1) begin
                    div_res_valid <= 1'b1;
                    div_res       <= div_a / div_b;
                end else begin
                    active <= 1'b1;
                    cnt    <= dly - 1;
                end
            end else if (active) begin
                if (cnt == 1) begin
                    active        <= 1'b0;
                    div_res_valid <= 1'b1;
                    div_res       <= m_a / m_b;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h want 0", busy); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %0h want 0", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %0h want 0", resp_valid); end
        checks++; if (div_v !== 1'b0) begin errors++; $display("FAIL reset_div_v: got %0h want 0", div_v); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout: got %0h want 0", err_timeout); end
        checks++; if ({resp_res, div_a, div_b} !== '0) begin errors++; $display("FAIL reset_data: got %0h/%0h/%0h want 0", resp_res, div_a, div_b); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int n;
        bit stable;
        bit extra_v;
        dly = 34; a0 = 100; b0 = 7; req_valid = 2'b01; resp_ready = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_accept: got %0h want 1", req_ready); end
        tick();
        req_valid = 2'b00;
        #1;
        checks++; if ({div_v, div_a, div_b} !== {1'b1, 32'd100, 32'd7}) begin errors++; $display("FAIL single_start: got v=%0h a=%0d b=%0d want v=1 a=100 b=7", div_v, div_a, div_b); end
        n = 1; stable = 1'b1; extra_v = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick(); n++;
            #1;
            if (div_a !== 32'd100 || div_b !== 32'd7) stable = 1'b0;
            if (div_v !== 1'b0) extra_v = 1'b1;
            if (resp_valid !== 2'b00) break;
        end
        checks++; if (n !== 36) begin errors++; $display("FAIL single_latency: got %0d want 36", n); end
        checks++; if (resp_valid !== 2'b01 || resp_res !== 32'd14) begin errors++; $display("FAIL single_result: got v=%0h r=%0d want v=1 r=14", resp_valid, resp_res); end
        checks++; if (stable !== 1'b1 || extra_v !== 1'b0) begin errors++; $display("FAIL single_operands_stable: got stable=%0b extra_v=%0b want 1/0", stable, extra_v); end
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin errors++; $display("FAIL single_idle_after: got busy=%0b v=%0h want 0/0", busy, resp_valid); end
    endtask

    task automatic test_contention();
        int grants[$];
        int acc_c[$];
        int resps[$];
        int viol;
        int resbad;
        bit gaps_ok;
        tick();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        a0 = 40; b0 = 5; a1 = 90; b1 = 9; dly = 1;
        req_valid = 2'b11; resp_ready = 2'b11;
        viol = 0; resbad = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (req_ready !== 2'b00) begin
                grants.push_back(req_ready[1] ? 1 : 0);
                acc_c.push_back(c);
                if (req_ready === 2'b11) viol++;
            end
            if (busy === 1'b1 && req_ready !== 2'b00) viol++;
            if (resp_valid !== 2'b00) begin
                resps.push_back(resp_valid[1] ? 1 : 0);
                if (resp_res !== (resp_valid[1] ? 32'd10 : 32'd8)) resbad++;
            end
            tick();
        end
        req_valid = 2'b00; resp_ready = 2'b00;
        checks++; if (grants.size() !== 4 || grants[0] !== 0 || grants[1] !== 1 || grants[2] !== 0 || grants[3] !== 1) begin errors++; $display("FAIL rr_grant_order: got n=%0d %p want 0,1,0,1", grants.size(), grants); end
        checks++; if (resps.size() !== 4 || resps[0] !== 0 || resps[1] !== 1 || resps[2] !== 0 || resps[3] !== 1) begin errors++; $display("FAIL rr_resp_order: got n=%0d %p want 0,1,0,1", resps.size(), resps); end
        gaps_ok = (acc_c.size() == 4);
        for (int i = 1; i < acc_c.size(); i++) if (acc_c[i] - acc_c[i-1] != 4) gaps_ok = 1'b0;
        checks++; if (gaps_ok !== 1'b1) begin errors++; $display("FAIL rr_turnaround: got %p want spacing 4", acc_c); end
        checks++; if (viol !== 0 || resbad !== 0) begin errors++; $display("FAIL rr_ready_results: got viol=%0d resbad=%0d want 0/0", viol, resbad); end
    endtask

    task automatic test_flush();
        int n;
        bit seen;
        a1 = 50; b1 = 5; dly = 5; req_valid = 2'b10; resp_ready = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL flush_accept: got %0h want 2", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        flush = 2'b10;
        tick();
        flush = 2'b00;
        n = 4; seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (resp_valid !== 2'b00) seen = 1'b1;
            if (busy === 1'b0) break;
            tick(); n++;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_resp: got %0b want 0", seen); end
        checks++; if (n !== 7) begin errors++; $display("FAIL flush_idle_cycle: got %0d want 7", n); end
        a0 = 9; b0 = 3; dly = 1; req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_next_accept: got %0h want 1", req_ready); end
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (resp_valid !== 2'b00) break;
            tick();
        end
        checks++; if (resp_valid !== 2'b01 || resp_res !== 32'd3) begin errors++; $display("FAIL flush_next_result: got v=%0h r=%0d want v=1 r=3", resp_valid, resp_res); end
        tick();
        resp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        int stablebad;
        int rrbad;
        a0 = 77; b0 = 7; a1 = 30; b1 = 6; dly = 1;
        req_valid = 2'b01; resp_ready = 2'b00;
        #1;
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (resp_valid !== 2'b00) break;
            tick();
        end
        req_valid = 2'b10;
        stablebad = 0; rrbad = 0;
        for (int k = 0; k < 10; k++) begin
            if (resp_valid !== 2'b01 || resp_res !== 32'd11) stablebad++;
            if (req_ready !== 2'b00) rrbad++;
            tick();
            #1;
        end
        checks++; if (stablebad !== 0) begin errors++; $display("FAIL bp_resp_stable: got %0d unstable cycles want 0", stablebad); end
        checks++; if (rrbad !== 0) begin errors++; $display("FAIL bp_no_ready: got %0d cycles want 0", rrbad); end
        resp_ready = 2'b01;
        #1;
        checks++; if (resp_valid !== 2'b01 || req_ready !== 2'b00) begin errors++; $display("FAIL bp_handshake: got v=%0h rdy=%0h want 1/0", resp_valid, req_ready); end
        tick();
        resp_ready = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b10 || busy !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got rdy=%0h busy=%0b want 2/0", req_ready, busy); end
        tick();
        req_valid = 2'b00; resp_ready = 2'b10;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (resp_valid !== 2'b00) break;
            tick();
        end
        checks++; if (resp_valid !== 2'b10 || resp_res !== 32'd5) begin errors++; $display("FAIL bp_port1_result: got v=%0h r=%0d want v=2 r=5", resp_valid, resp_res); end
        tick();
        resp_ready = 2'b00;
    endtask

    task automatic test_timeout();
        int n;
        never = 1'b1; a0 = 1; b0 = 1; req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        #1;
        checks++; if (div_v !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL to_start: got v=%0b err=%0b want 1/0", div_v, err_timeout); end
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick(); n++;
            #1;
            if (resp_valid !== 2'b00) break;
        end
        checks++; if (n !== 65) begin errors++; $display("FAIL to_latency: got %0d want 65", n); end
        checks++; if (resp_valid !== 2'b01 || resp_res !== 32'hFFFF_FFFF || err_timeout !== 1'b1) begin errors++; $display("FAIL to_result: got v=%0h r=%0h err=%0b want 1/ffffffff/1", resp_valid, resp_res, err_timeout); end
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00; never = 1'b0; dly = 3; a0 = 20; b0 = 4; req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00; resp_ready = 2'b01;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (resp_valid !== 2'b00) break;
            tick();
        end
        checks++; if (resp_res !== 32'd5 || err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got r=%0d err=%0b want 5/1", resp_res, err_timeout); end
        tick();
        resp_ready = 2'b00;
    endtask

    task automatic test_reset_mid();
        dly = 30; a0 = 50; b0 = 5; req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %0b want 1", busy); end
        rst_n = 1'b0;
        req_valid = 2'b01;
        #1;
        checks++; if (busy !== 1'b0 || req_ready !== 2'b00 || resp_valid !== 2'b00 || div_v !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got busy=%0b rdy=%0h v=%0h dv=%0b want 0", busy, req_ready, resp_valid, div_v); end
        checks++; if ({div_a, div_b, resp_res, err_timeout} !== '0) begin errors++; $display("FAIL rmid_data: got a=%0h b=%0h r=%0h err=%0b want 0", div_a, div_b, resp_res, err_timeout); end
        tick();
        tick();
        rst_n = 1'b1; a0 = 64; b0 = 8; dly = 2;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_accept: got %0h want 1", req_ready); end
        tick();
        req_valid = 2'b00; resp_ready = 2'b01;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (resp_valid !== 2'b00) break;
            tick();
        end
        checks++; if (resp_valid !== 2'b01 || resp_res !== 32'd8) begin errors++; $display("FAIL rmid_result: got v=%0h r=%0d want 1/8", resp_valid, resp_res); end
        tick();
        resp_ready = 2'b00;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %0b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_flush();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish before 100000");
        $fatal(1, "simulation time limit");
    end

endmodule
